// File: rtl/fpu_pkg.sv
// fpu_pkg: shared op encoding and IEEE-754 constants for the add/sub scheduler
package fpu_pkg;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} fpu_op_e;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] ONE = 32'h3F80_0000;
endpackage

// File: rtl/add_fpu.sv
// add_fpu: combinational single-precision adder, truncating, denormals flushed to zero
module add_fpu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        nan_error
);
  logic [31:0] x, y;
  logic [27:0] mx, my, mys, sum;
  logic [22:0] n;
  logic [7:0]  d;
  logic [4:0]  lz;
  logic [9:0]  e;
  logic        a_nan, b_nan, a_inf, b_inf;
  // order by magnitude, align, add/subtract, normalise, then apply special cases
  always_comb begin
    a_nan = &a[30:23] & |a[22:0];
    b_nan = &b[30:23] & |b[22:0];
    a_inf = &a[30:23] & ~|a[22:0];
    b_inf = &b[30:23] & ~|b[22:0];
    x = b[30:0] > a[30:0] ? b : a;
    y = b[30:0] > a[30:0] ? a : b;
    mx = x[30:23] == 8'd0 ? '0 : {2'b01, x[22:0], 3'b000};
    my = y[30:23] == 8'd0 ? '0 : {2'b01, y[22:0], 3'b000};
    d = x[30:23] - y[30:23];
    mys = my >> d;
    sum = (x[31] ^ y[31]) ? mx - mys : mx + mys;
    lz = 5'd0;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    n = 23'((sum << lz) >> 3);
    e = sum[27] ? {2'b00, x[30:23]} + 10'd1 : {2'b00, x[30:23]} - {5'b00000, lz};
    nan_error = a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31]));
    result = nan_error ? fpu_pkg::QNAN :
             a_inf ? a :
             b_inf ? b :
             (sum == 28'd0 || e[9] || e == 10'd0) ? 32'd0 :
             e >= 10'd255 ? {x[31], 8'hFF, 23'd0} :
             {x[31], e[7:0], sum[27] ? sum[26:4] : n};
  end
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, requester 0 wins the first tie after reset
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);
  logic last;
  // a tie goes to whichever requester did not win last time
  always_comb grant = ~en ? 2'b00 : &req ? (last ? 2'b01 : 2'b10) : req;
  // remember the most recent winner
  always_ff @(posedge clk)
    if (rst) last <= 1'b1;
    else if (|grant) last <= grant[1];
endmodule

// File: rtl/fpu_addsub_scheduler.sv
// fpu_addsub_scheduler: round-robin sharing of one adder between two add/sub requesters
module fpu_addsub_scheduler
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_op,
  input  logic [1:0][31:0]      req_a,
  input  logic [1:0][31:0]      req_b,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic [31:0]           rsp_result,
  output logic                  rsp_nan,
  output logic                  busy,
  output logic [CNT_W-1:0]      nan_count
);
  logic [1:0]       grant;
  logic             adv1, adv2, w;
  logic             s1_valid, s1_id;
  logic [TAG_W-1:0] s1_tag;
  logic [31:0]      s1_a, s1_b, sum;
  logic             sum_nan;
  assign adv2 = ~rsp_valid | rsp_ready;
  assign adv1 = ~s1_valid | adv2;
  assign w = grant[1];
  assign req_ready = grant;
  assign busy = s1_valid | rsp_valid;
  rr_arb2 u_arb (.clk(clk), .rst(rst), .req(req_valid), .en(adv1 & ~flush & ~rst), .grant(grant));
  add_fpu u_add (.a(s1_a), .b(s1_b), .result(sum), .nan_error(sum_nan));
  // operand stage: subtraction becomes addition with B's sign flipped
  always_ff @(posedge clk)
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id <= 1'b0;
      s1_tag <= '0;
      s1_a <= '0;
      s1_b <= '0;
    end else if (flush) s1_valid <= 1'b0;
    else if (adv1) begin
      s1_valid <= |grant;
      s1_id <= w;
      s1_tag <= req_tag[w];
      s1_a <= req_a[w];
      s1_b <= fpu_op_e'(req_op[w]) == OP_SUB ? {~req_b[w][31], req_b[w][30:0]} : req_b[w];
    end
  // result stage doubles as the response register, held while the consumer stalls
  always_ff @(posedge clk)
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_tag <= '0;
      rsp_result <= '0;
      rsp_nan <= 1'b0;
    end else if (flush) rsp_valid <= 1'b0;
    else if (adv2) begin
      rsp_valid <= s1_valid;
      rsp_id <= s1_id;
      rsp_tag <= s1_tag;
      rsp_result <= sum;
      rsp_nan <= sum_nan;
    end
  // saturating count of NaN responses actually handed over
  always_ff @(posedge clk)
    if (rst) nan_count <= '0;
    else if (rsp_valid & rsp_ready & rsp_nan & ~flush & ~&nan_count) nan_count <= nan_count + CNT_W'(1);
endmodule

// File: tb/tb_fpu_addsub_scheduler.sv
// tb_fpu_addsub_scheduler: directed checks of arbitration, latency, backpressure, NaN count, flush/reset
module tb_fpu_addsub_scheduler;
  import fpu_pkg::*;
  logic            clk = 1'b0;
  logic            rst, flush, rsp_ready;
  logic [1:0]      req_valid, req_ready, req_op;
  logic [1:0][31:0] req_a, req_b;
  logic [1:0][3:0] req_tag;
  logic            rsp_valid, rsp_id, rsp_nan, busy;
  logic [3:0]      rsp_tag;
  logic [31:0]     rsp_result;
  logic [1:0]      nan_count;
  int              n_cmp = 0;
  int              n_bad = 0;

  fpu_addsub_scheduler #(.TAG_W(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_result(rsp_result), .rsp_nan(rsp_nan), .busy(busy), .nan_count(nan_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    req_op[i] = op;
    req_a[i] = a;
    req_b[i] = b;
    req_tag[i] = t;
  endtask

  initial begin
    rst = 1; flush = 0; rsp_ready = 0; req_valid = 2'b11; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    go(); go(); #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_nan_count", nan_count, 0);
    go(); rst = 0; rsp_ready = 1; req_valid = 0;
    // single add from requester 0
    set_req(0, OP_ADD, ONE, 32'h4000_0000, 4'd3); req_valid = 2'b01; #1;
    chk("t1_ready", req_ready, 2'b01);
    go(); req_valid = 0; #1;
    chk("t1_busy", busy, 1);
    chk("t1_not_yet", rsp_valid, 0);
    go(); #1;
    chk("t1_valid", rsp_valid, 1);
    chk("t1_result", rsp_result, 32'h4040_0000);
    chk("t1_id", rsp_id, 0);
    chk("t1_tag", rsp_tag, 3);
    chk("t1_nan", rsp_nan, 0);
    // single sub from requester 1
    go(); set_req(1, OP_SUB, 32'h4040_0000, ONE, 4'd5); req_valid = 2'b10; #1;
    chk("t2_ready", req_ready, 2'b10);
    go(); req_valid = 0; go(); #1;
    chk("t2_valid", rsp_valid, 1);
    chk("t2_result", rsp_result, 32'h4000_0000);
    chk("t2_id", rsp_id, 1);
    chk("t2_tag", rsp_tag, 5);
    // both requesters held: alternation after reset starts at 0
    go(); rst = 1; go(); rst = 0;
    set_req(0, OP_ADD, ONE, 32'h4000_0000, 4'd0);
    set_req(1, OP_SUB, 32'h4040_0000, ONE, 4'd1);
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k < 6) chk("t3_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
      if (k >= 2) begin
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_id", rsp_id, k % 2);
        chk("t3_rsp_result", rsp_result, (k % 2) ? 32'h4000_0000 : 32'h4040_0000);
      end
      go();
      req_valid = (k < 5) ? 2'b11 : 2'b00;
    end
    #1;
    chk("t3_drained", rsp_valid, 0);
    // backpressure: two accepted, third held off until release
    rsp_ready = 0;
    set_req(0, OP_ADD, ONE, ONE, 4'd7); req_valid = 2'b01; #1;
    chk("t4_acc0", req_ready, 2'b01);
    go(); set_req(0, OP_ADD, 32'h4000_0000, 32'h4000_0000, 4'd8); #1;
    chk("t4_acc1", req_ready, 2'b01);
    go(); set_req(0, OP_ADD, 32'h4040_0000, 32'h4040_0000, 4'd9);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_blocked", req_ready, 2'b00);
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_tag", rsp_tag, 7);
      chk("t4_hold_result", rsp_result, 32'h4000_0000);
      go();
    end
    rsp_ready = 1; #1;
    chk("t4_release_ready", req_ready, 2'b01);
    chk("t4_release_tag", rsp_tag, 7);
    go(); req_valid = 0; #1;
    chk("t4_second_tag", rsp_tag, 8);
    chk("t4_second_result", rsp_result, 32'h4080_0000);
    go(); #1;
    chk("t4_third_tag", rsp_tag, 9);
    chk("t4_third_result", rsp_result, 32'h40C0_0000);
    go(); #1;
    chk("t4_empty", rsp_valid, 0);
    // NaN results and counter saturation (2-bit counter)
    set_req(0, OP_ADD, QNAN, ONE, 4'd2); req_valid = 2'b01;
    go(); req_valid = 0; go(); #1;
    chk("t5_nan", rsp_nan, 1);
    chk("t5_qnan", rsp_result, QNAN);
    chk("t5_cnt_before", nan_count, 0);
    go(); #1;
    chk("t5_cnt_after", nan_count, 1);
    req_valid = 2'b01;
    go(); go(); go(); req_valid = 0;
    go(); go(); go(); #1;
    chk("t5_cnt_sat", nan_count, 2'b11);
    set_req(1, OP_SUB, 32'h7F80_0000, 32'h7F80_0000, 4'd4); req_valid = 2'b10;
    go(); req_valid = 0; go(); #1;
    chk("t5_inf_minus_inf", rsp_nan, 1);
    go(); #1;
    chk("t5_cnt_still_sat", nan_count, 2'b11);
    // flush with both stages full and a request pending
    rsp_ready = 0;
    set_req(0, OP_ADD, ONE, ONE, 4'd10); req_valid = 2'b01;
    go(); set_req(0, OP_ADD, ONE, ONE, 4'd11);
    go(); set_req(0, OP_ADD, ONE, ONE, 4'd12); flush = 1; #1;
    chk("t6f_busy_before", busy, 1);
    chk("t6f_ready_during", req_ready, 2'b00);
    go(); flush = 0; #1;
    chk("t6f_busy_after", busy, 0);
    chk("t6f_no_rsp", rsp_valid, 0);
    chk("t6f_accept_next", req_ready, 2'b01);
    go(); req_valid = 0; rsp_ready = 1; #1;
    chk("t6f_gap", rsp_valid, 0);
    go(); #1;
    chk("t6f_rsp_valid", rsp_valid, 1);
    chk("t6f_rsp_tag", rsp_tag, 12);
    chk("t6f_cnt_kept", nan_count, 2'b11);
    // reset with both stages full and a request pending
    go(); rsp_ready = 0;
    set_req(0, OP_ADD, QNAN, ONE, 4'd13); req_valid = 2'b01;
    go(); go(); set_req(0, OP_SUB, 32'h4040_0000, ONE, 4'd14); rst = 1; #1;
    chk("t6r_ready_during", req_ready, 2'b00);
    go(); rst = 0; #1;
    chk("t6r_busy_after", busy, 0);
    chk("t6r_no_rsp", rsp_valid, 0);
    chk("t6r_cnt_zero", nan_count, 0);
    chk("t6r_accept_next", req_ready, 2'b01);
    go(); req_valid = 0; rsp_ready = 1;
    go(); #1;
    chk("t6r_rsp_tag", rsp_tag, 14);
    chk("t6r_rsp_result", rsp_result, 32'h4000_0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
